// File: rtl/aemb2_sram_pkg.sv
// Shared types for the dual-port Wishbone SRAM: port FSM states and byte-lane select values.
package aemb2_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } sram_state_e;

    localparam int WAIT_W = 3;

    localparam logic [3:0] SEL_NONE = 4'h0;
    localparam logic [3:0] SEL_B0   = 4'h1;
    localparam logic [3:0] SEL_B1   = 4'h2;
    localparam logic [3:0] SEL_B2   = 4'h4;
    localparam logic [3:0] SEL_B3   = 4'h8;
    localparam logic [3:0] SEL_H0   = 4'h3;
    localparam logic [3:0] SEL_H1   = 4'hC;
    localparam logic [3:0] SEL_W    = 4'hF;

endpackage

// File: rtl/aemb2_sram_port.sv
// One Wishbone slave handshake: IDLE -> (WAIT x N) -> ACK, single-cycle ack, no stb re-sample.
module aemb2_sram_port
    import aemb2_sram_pkg::*;
#(
    parameter int WAIT = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    output logic accept_o,
    output logic ack_o
);

    sram_state_e       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stb_i) begin
                    accept_o = 1'b1;
                    cnt_d    = WAIT_W'(WAIT);
                    state_d  = (WAIT > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                // A zero count here is unreachable; treat it like 1 so the FSM cannot stall.
                if (cnt_q <= WAIT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack_o = (state_q == ST_ACK);

endmodule

// File: rtl/aemb2_wb_sram.sv
// Dual-port (instruction read / data read-write) Wishbone SRAM with configurable wait states.
// Define AEMB2_SRAM_WPROT_EN to make words below ROM_TOP write-protected (error instead of ack).
module aemb2_wb_sram
    import aemb2_sram_pkg::*;
#(
    parameter int AW      = 14,
    parameter int WAIT    = 0,
    parameter int ROM_TOP = 0
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_ni,
    input  logic [AW-1:0] iwb_adr_i,
    input  logic          iwb_stb_i,
    output logic          iwb_ack_o,
    output logic [31:0]   iwb_dat_o,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [31:0]   dwb_dat_i,
    output logic          dwb_ack_o,
    output logic          dwb_err_o,
    output logic [31:0]   dwb_dat_o
);

    localparam int DEPTH = 1 << AW;

    logic        i_accept, i_ack;
    logic        d_accept, d_ack;
    logic        d_wr_block, d_wr_en, d_rd_en;
    logic [31:0] i_rd, d_rd;
    logic        i_rdv_q, i_rdv_d;
    logic        d_rdv_q, d_rdv_d;

    aemb2_sram_port #(.WAIT(WAIT)) u_iport (
        .clk_i   (sys_clk_i),
        .rst_ni  (sys_rst_ni),
        .stb_i   (iwb_stb_i),
        .accept_o(i_accept),
        .ack_o   (i_ack)
    );

    aemb2_sram_port #(.WAIT(WAIT)) u_dport (
        .clk_i   (sys_clk_i),
        .rst_ni  (sys_rst_ni),
        .stb_i   (dwb_stb_i),
        .accept_o(d_accept),
        .ack_o   (d_ack)
    );

    assign d_wr_en = d_accept & dwb_wre_i & ~d_wr_block;
    assign d_rd_en = d_accept & ~dwb_wre_i;

    // One byte-wide array per lane; writes and both reads share a single edge so a
    // same-edge iwb read of a word being written returns the old contents.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_b [DEPTH];
        logic [7:0] i_rd_q;
        logic [7:0] d_rd_q;

        always_ff @(posedge sys_clk_i) begin
            if (d_wr_en && dwb_sel_i[gi]) begin
                mem_b[dwb_adr_i] <= dwb_dat_i[gi*8 +: 8];
            end
            if (i_accept) begin
                i_rd_q <= mem_b[iwb_adr_i];
            end
            if (d_rd_en) begin
                d_rd_q <= mem_b[dwb_adr_i];
            end
        end

        assign i_rd[gi*8 +: 8] = i_rd_q;
        assign d_rd[gi*8 +: 8] = d_rd_q;
    end

    // The read registers stay reset-free so they map onto the RAM primitive; these
    // valid flags give the zero-after-reset output instead.
    always_comb begin
        i_rdv_d = i_rdv_q | i_accept;
        d_rdv_d = d_rdv_q | d_rd_en;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            i_rdv_q <= 1'b0;
            d_rdv_q <= 1'b0;
        end else begin
            i_rdv_q <= i_rdv_d;
            d_rdv_q <= d_rdv_d;
        end
    end

    assign iwb_ack_o = i_ack;
    assign iwb_dat_o = i_rdv_q ? i_rd : 32'h0;
    assign dwb_dat_o = d_rdv_q ? d_rd : 32'h0;

`ifdef AEMB2_SRAM_WPROT_EN
    logic prot_q, prot_d;

    assign d_wr_block = (32'(dwb_adr_i) < 32'(ROM_TOP));

    always_comb begin
        prot_d = prot_q;
        if (d_accept) begin
            prot_d = dwb_wre_i & d_wr_block;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            prot_q <= 1'b0;
        end else begin
            prot_q <= prot_d;
        end
    end

    assign dwb_ack_o = d_ack & ~prot_q;
    assign dwb_err_o = d_ack & prot_q;
`else
    logic unused_rom_top;

    assign unused_rom_top = (ROM_TOP != 0);
    assign d_wr_block     = 1'b0;
    assign dwb_ack_o      = d_ack;
    assign dwb_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_aemb2_wb_sram.sv
// Directed bench for aemb2_wb_sram: four instances (WAIT 0/3/5, and one with ROM_TOP=0x100).
module tb_aemb2_wb_sram;
    import aemb2_sram_pkg::*;

`ifdef AEMB2_SRAM_WPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [13:0] iadr  [4];
    logic        istb  [4];
    logic        iack  [4];
    logic [31:0] idat  [4];
    logic [13:0] dadr  [4];
    logic        dstb  [4];
    logic        dwre  [4];
    logic [3:0]  dsel  [4];
    logic [31:0] dwdat [4];
    logic        dack  [4];
    logic        derr  [4];
    logic [31:0] ddat  [4];

    int n_cmp = 0;
    int n_bad = 0;

    aemb2_wb_sram #(.WAIT(0)) u0 (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .iwb_adr_i(iadr[0]), .iwb_stb_i(istb[0]), .iwb_ack_o(iack[0]), .iwb_dat_o(idat[0]),
        .dwb_adr_i(dadr[0]), .dwb_stb_i(dstb[0]), .dwb_wre_i(dwre[0]), .dwb_sel_i(dsel[0]),
        .dwb_dat_i(dwdat[0]), .dwb_ack_o(dack[0]), .dwb_err_o(derr[0]), .dwb_dat_o(ddat[0]));

    aemb2_wb_sram #(.WAIT(3)) u3 (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .iwb_adr_i(iadr[1]), .iwb_stb_i(istb[1]), .iwb_ack_o(iack[1]), .iwb_dat_o(idat[1]),
        .dwb_adr_i(dadr[1]), .dwb_stb_i(dstb[1]), .dwb_wre_i(dwre[1]), .dwb_sel_i(dsel[1]),
        .dwb_dat_i(dwdat[1]), .dwb_ack_o(dack[1]), .dwb_err_o(derr[1]), .dwb_dat_o(ddat[1]));

    aemb2_wb_sram #(.WAIT(5)) u5 (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .iwb_adr_i(iadr[2]), .iwb_stb_i(istb[2]), .iwb_ack_o(iack[2]), .iwb_dat_o(idat[2]),
        .dwb_adr_i(dadr[2]), .dwb_stb_i(dstb[2]), .dwb_wre_i(dwre[2]), .dwb_sel_i(dsel[2]),
        .dwb_dat_i(dwdat[2]), .dwb_ack_o(dack[2]), .dwb_err_o(derr[2]), .dwb_dat_o(ddat[2]));

    aemb2_wb_sram #(.WAIT(0), .ROM_TOP('h100)) up (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .iwb_adr_i(iadr[3]), .iwb_stb_i(istb[3]), .iwb_ack_o(iack[3]), .iwb_dat_o(idat[3]),
        .dwb_adr_i(dadr[3]), .dwb_stb_i(dstb[3]), .dwb_wre_i(dwre[3]), .dwb_sel_i(dsel[3]),
        .dwb_dat_i(dwdat[3]), .dwb_ack_o(dack[3]), .dwb_err_o(derr[3]), .dwb_dat_o(ddat[3]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // op: 0 = dwb write, 1 = dwb read, 2 = iwb read. Latency counts edges after accept.
    task automatic xfer(input int k, input int op, input logic [13:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int exp_lat, input logic exp_err,
                        output logic [31:0] rdat);
        int   lat;
        logic fired;
        logic err_seen;
        lat      = -1;
        err_seen = 1'b0;
        rdat     = '0;
        @(negedge clk);
        if (op == 2) begin
            iadr[k] = adr;
            istb[k] = 1'b1;
        end else begin
            dadr[k]  = adr;
            dwre[k]  = (op == 0);
            dsel[k]  = sel;
            dwdat[k] = dat;
            dstb[k]  = 1'b1;
        end
        @(posedge clk);
        #1;
        istb[k] = 1'b0;
        dstb[k] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            fired = (op == 2) ? iack[k] : (dack[k] | derr[k]);
            if (fired) begin
                lat      = i;
                err_seen = (op == 2) ? 1'b0 : derr[k];
                rdat     = (op == 2) ? idat[k] : ddat[k];
                break;
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (op != 2) chk("err_flag", {31'b0, err_seen}, {31'b0, exp_err});
        if (lat >= 0) begin
            @(negedge clk);
            chk("ack_width", {31'b0, iack[k] | dack[k] | derr[k]}, 32'h0);
        end
        $display("xfer inst %0d op %0d adr %h sel %h wdat %h lat %0d err %0b rdat %h",
                 k, op, adr, sel, dat, lat, err_seen, rdat);
    endtask

    typedef struct {
        int          op;
        logic [13:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        any_ack;

        tbl[0]  = '{0, 14'h10, SEL_W,    32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1, 14'h10, SEL_NONE, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{2, 14'h10, SEL_NONE, 32'h0,        32'hDEADBEEF};
        tbl[3]  = '{0, 14'h20, SEL_W,    32'h11223344, 32'h0};
        tbl[4]  = '{0, 14'h20, SEL_B1,   32'h0000AA00, 32'h0};
        tbl[5]  = '{1, 14'h20, SEL_NONE, 32'h0,        32'h1122AA44};
        tbl[6]  = '{0, 14'h20, SEL_H1,   32'h55660000, 32'h0};
        tbl[7]  = '{1, 14'h20, SEL_NONE, 32'h0,        32'h5566AA44};
        tbl[8]  = '{0, 14'h24, SEL_W,    32'h00000000, 32'h0};
        tbl[9]  = '{0, 14'h24, SEL_B3,   32'h7F000000, 32'h0};
        tbl[10] = '{0, 14'h24, SEL_B0,   32'h000000A5, 32'h0};
        tbl[11] = '{0, 14'h24, SEL_NONE, 32'hFFFFFFFF, 32'h0};
        tbl[12] = '{1, 14'h24, SEL_NONE, 32'h0,        32'h7F0000A5};
        tbl[13] = '{0, 14'h24, SEL_B2,   32'h00BB0000, 32'h0};
        tbl[14] = '{2, 14'h24, SEL_NONE, 32'h0,        32'h7FBB00A5};
        tbl[15] = '{0, 14'h30, SEL_W,    32'h00000000, 32'h0};
        tbl[16] = '{1, 14'h10, SEL_NONE, 32'h0,        32'hDEADBEEF};

        for (int k = 0; k < 4; k++) begin
            iadr[k] = '0; istb[k] = 1'b0; dadr[k] = '0; dstb[k] = 1'b0;
            dwre[k] = 1'b0; dsel[k] = '0; dwdat[k] = '0;
        end

        // Asynchronous reset: checked before the first clock edge.
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            chk("rst_iack", {31'b0, iack[k]}, 32'h0);
            chk("rst_dack", {31'b0, dack[k]}, 32'h0);
            chk("rst_derr", {31'b0, derr[k]}, 32'h0);
            chk("rst_idat", idat[k], 32'h0);
            chk("rst_ddat", ddat[k], 32'h0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // WAIT=0 vector table.
        for (int v = 0; v < 17; v++) begin
            xfer(0, tbl[v].op, tbl[v].adr, tbl[v].sel, tbl[v].dat, 0, 1'b0, rd);
            if (tbl[v].op != 0) chk("table_rdata", rd, tbl[v].exp);
        end

        // Same-edge dwb write and iwb read of word 0x30.
        @(negedge clk);
        dadr[0] = 14'h30; dwre[0] = 1'b1; dsel[0] = SEL_W; dwdat[0] = 32'hCAFEF00D; dstb[0] = 1'b1;
        iadr[0] = 14'h30; istb[0] = 1'b1;
        @(posedge clk);
        #1;
        dstb[0] = 1'b0;
        istb[0] = 1'b0;
        @(negedge clk);
        chk("same_edge_iack", {31'b0, iack[0]}, 32'h1);
        chk("same_edge_dack", {31'b0, dack[0]}, 32'h1);
        chk("same_edge_idat", idat[0], 32'h0);
        $display("same-edge write/read adr 030 iack %0b dack %0b idat %h", iack[0], dack[0], idat[0]);
        xfer(0, 2, 14'h30, SEL_NONE, 32'h0, 0, 1'b0, rd);
        chk("iwb_after_write", rd, 32'hCAFEF00D);

        // WAIT=3: latency, then stb held continuously.
        xfer(1, 0, 14'h5, SEL_W, 32'h01020304, 3, 1'b0, rd);
        xfer(1, 1, 14'h5, SEL_NONE, 32'h0, 3, 1'b0, rd);
        chk("wait3_rdata", rd, 32'h01020304);
        @(negedge clk);
        dadr[1] = 14'h5; dwre[1] = 1'b0; dstb[1] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stream_ack", {31'b0, dack[1]}, {31'b0, (c % 5) == 4});
            if (dack[1]) chk("stream_rdata", ddat[1], 32'h01020304);
            $display("stream cycle %0d ack %0b", c, dack[1]);
        end
        dstb[1] = 1'b0;

        // WAIT=5: reset pulse mid-transfer abandons the ack but keeps the write.
        @(negedge clk);
        dadr[2] = 14'h44; dwre[2] = 1'b1; dsel[2] = SEL_W; dwdat[2] = 32'hA5A5A5A5; dstb[2] = 1'b1;
        @(posedge clk);
        #1;
        dstb[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dack", {31'b0, dack[2]}, 32'h0);
        chk("midrst_ddat", ddat[2], 32'h0);
        chk("midrst_u0_ddat", ddat[0], 32'h0);
        chk("midrst_u0_idat", idat[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        any_ack = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            any_ack = any_ack | dack[2] | derr[2];
        end
        chk("no_ack_after_reset", {31'b0, any_ack}, 32'h0);
        $display("reset during wait: ack seen afterwards %0b", any_ack);
        xfer(2, 1, 14'h44, SEL_NONE, 32'h0, 5, 1'b0, rd);
        chk("write_kept_after_reset", rd, 32'hA5A5A5A5);

        // ROM_TOP=0x100 instance: protection only when the feature is compiled in.
        xfer(3, 0, 14'h80, SEL_W, 32'h11111111, 0, WP, rd);
        xfer(3, 0, 14'hFF, SEL_W, 32'h33333333, 0, WP, rd);
        xfer(3, 1, 14'h80, SEL_NONE, 32'h0, 0, 1'b0, rd);
        if (WP) chk("rom_unchanged", {31'b0, rd != 32'h11111111}, 32'h1);
        else    chk("rom_written", rd, 32'h11111111);
        xfer(3, 0, 14'h100, SEL_W, 32'h22222222, 0, 1'b0, rd);
        xfer(3, 1, 14'h100, SEL_NONE, 32'h0, 0, 1'b0, rd);
        chk("ram_top_written", rd, 32'h22222222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
